router_pkt_fifo: RTL and testbench

//  Parametrised, packet-aware output FIFO for one router destination channel.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_pkt_fifo_if.sv | 44 ++++
 rtl/router_pkt_counter.sv | 54 +++++
 rtl/router_pkt_fifo.sv | 116 +++++++++++
 tb/tb_router_pkt_fifo.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet FIFO: header length field position,
// the stored word layout and a constant clog2 helper.
package router_pkg;

    localparam int LEN_LSB    = 2;
    localparam int PKT_DATA_W = 8;

    typedef struct packed {
        logic                  tag;
        logic [PKT_DATA_W-1:0] data;
    } fifo_word_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Handshake/data bundle between the router write stage and the channel read port.
// The level/almost_full pair exists only when ROUTER_FIFO_LEVEL_EN is defined.
interface router_pkt_fifo_if #(
    parameter int DATA_W = 8
`ifdef ROUTER_FIFO_LEVEL_EN
    , parameter int LVL_W = 5
`endif
);

    logic              write_enb;
    logic              read_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              full;
    logic              empty;
    logic              pkt_busy;
    logic              pkt_done;
    logic              overflow_err;
`ifdef ROUTER_FIFO_LEVEL_EN
    logic [LVL_W-1:0]  level;
    logic              almost_full;
`endif

    modport master (
`ifdef ROUTER_FIFO_LEVEL_EN
        input  level,
        input  almost_full,
`endif
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, out_valid, full, empty, pkt_busy, pkt_done, overflow_err
    );

    modport slave (
`ifdef ROUTER_FIFO_LEVEL_EN
        output level,
        output almost_full,
`endif
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, out_valid, full, empty, pkt_busy, pkt_done, overflow_err
    );

endinterface

// File: rtl/router_pkt_counter.sv
// Remaining-byte tracker for the packet being read out: reloads on a header,
// counts down on payload/parity, pulses pkt_done when the parity byte leaves.
module router_pkt_counter
    import router_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      soft_reset,
    input  logic                      rd_accept,
    input  logic                      rd_tag,
    input  logic [DATA_W-LEN_LSB-1:0] rd_len,
    output logic [DATA_W-2:0]         count,
    output logic                      pkt_busy,
    output logic                      pkt_done
);

    localparam int CNT_W = DATA_W - 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (soft_reset) begin
            count_d = '0;
        end else if (rd_accept) begin
            // A header always reloads, even if the previous packet was cut short.
            if (rd_tag) begin
                count_d = CNT_W'(rd_len) + 1'b1;
            end else if (count_q != '0) begin
                count_d = count_q - 1'b1;
                done_d  = (count_q == CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count    = count_q;
    assign pkt_busy = (count_q != '0);
    assign pkt_done = done_q;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router destination channel.
// Define ROUTER_FIFO_LEVEL_EN to add the occupancy (level) and almost_full outputs.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               soft_reset,
    router_pkt_fifo_if.slave   bus
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              lfd_q, lfd_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   rd_word;
    logic              full, empty;
    logic              wr_accept, rd_accept;
    logic [DATA_W-2:0] count;

    assign full      = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign wr_accept = bus.write_enb && !full;
    assign rd_accept = bus.read_enb && !empty;
    assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        lfd_d       = bus.lfd_state;
        overflow_d  = overflow_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            lfd_d      = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (bus.write_enb && full) overflow_d = 1'b1;
            if (rd_accept) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                data_out_d  = rd_word[DATA_W-1:0];
                out_valid_d = 1'b1;
            end else if (count == '0 && empty) begin
                // Idle with nothing pending: return the bus to zero.
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            lfd_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            lfd_q       <= lfd_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; stale words become unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (wr_accept && !soft_reset) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, bus.data_in};
    end

    router_pkt_counter #(.DATA_W(DATA_W)) u_counter (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .rd_accept  (rd_accept),
        .rd_tag     (rd_word[DATA_W]),
        .rd_len     (rd_word[DATA_W-1:LEN_LSB]),
        .count      (count),
        .pkt_busy   (bus.pkt_busy),
        .pkt_done   (bus.pkt_done)
    );

    assign bus.data_out     = data_out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.overflow_err = overflow_q;

`ifdef ROUTER_FIFO_LEVEL_EN
    localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];
    logic [AW:0] level;
    assign level           = wr_ptr_q - rd_ptr_q;
    assign bus.level       = level;
    assign bus.almost_full = (level >= AF_LVL);
`else
    logic unused_af;
    assign unused_af = ^AF_THRESH;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo against a queue-based packet FIFO model.
module tb_router_pkt_fifo;
    import router_pkg::*;

    localparam int DEPTH = 16;

    logic clk        = 1'b0;
    logic resetn     = 1'b1;
    logic soft_reset = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    router_pkt_fifo_if #(
        .DATA_W(8)
`ifdef ROUTER_FIFO_LEVEL_EN
        , .LVL_W(5)
`endif
    ) bus ();

    router_pkt_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(14)) dut (
        .clock      (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    fifo_word_t q[$];
    fifo_word_t w;
    logic [7:0] m_dout = 8'h00;
    logic       m_vld  = 1'b0;
    logic       m_done = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       m_lfd  = 1'b0;
    int         m_cnt  = 0;
    bit         do_rd, do_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dout = 8'h00;
        m_vld  = 1'b0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_lfd  = 1'b0;
        m_cnt  = 0;
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn || soft_reset) begin
            model_clear();
        end else begin
            do_rd  = bus.read_enb && (q.size() != 0);
            do_wr  = bus.write_enb && (q.size() != DEPTH);
            if (bus.write_enb && q.size() == DEPTH) m_ovf = 1'b1;
            m_done = 1'b0;
            if (do_rd) begin
                w      = q.pop_front();
                m_dout = w.data;
                m_vld  = 1'b1;
                if (w.tag) m_cnt = int'(w.data >> 2) + 1;
                else if (m_cnt > 0) begin
                    if (m_cnt == 1) m_done = 1'b1;
                    m_cnt = m_cnt - 1;
                end
            end else begin
                m_vld = 1'b0;
                if (m_cnt == 0 && q.size() == 0) m_dout = 8'h00;
            end
            if (do_wr) begin
                w.tag  = m_lfd;
                w.data = bus.data_in;
                q.push_back(w);
            end
            m_lfd = bus.lfd_state;
        end
    end

    always @(negedge clk) begin
        chk("data_out",     32'(bus.data_out),     32'(m_dout));
        chk("out_valid",    32'(bus.out_valid),    32'(m_vld));
        chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
        chk("empty",        32'(bus.empty),        32'(q.size() == 0));
        chk("pkt_busy",     32'(bus.pkt_busy),     32'(m_cnt != 0));
        chk("pkt_done",     32'(bus.pkt_done),     32'(m_done));
        chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
`ifdef ROUTER_FIFO_LEVEL_EN
        chk("level",        32'(bus.level),        32'(q.size()));
        chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= 14));
`endif
    end

    task automatic step(input logic wr, input logic rd, input logic lfd, input logic [7:0] d);
        bus.write_enb = wr;
        bus.read_enb  = rd;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Asynchronous reset in the middle of a write
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h08);
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(0, 1, 0, 8'h00);
        chk("pre_rst_data", 32'(bus.data_out), 32'h08);
        chk("pre_rst_busy", 32'(bus.pkt_busy), 32'd1);
        bus.write_enb = 1'b1;
        bus.data_in   = 8'h33;
        resetn        = 1'b0;
        #1;
        chk("rst_data_out",  32'(bus.data_out),     32'd0);
        chk("rst_out_valid", 32'(bus.out_valid),    32'd0);
        chk("rst_full",      32'(bus.full),         32'd0);
        chk("rst_empty",     32'(bus.empty),        32'd1);
        chk("rst_pkt_busy",  32'(bus.pkt_busy),     32'd0);
        chk("rst_overflow",  32'(bus.overflow_err), 32'd0);
        @(posedge clk);
        #1;
        bus.write_enb = 1'b0;
        resetn        = 1'b1;

        // Fill to full, then overflow
        for (int i = 0; i < 15; i++) step(1, 0, 0, 8'h40 + 8'(i));
        chk("full_at_15", 32'(bus.full), 32'd0);
        step(1, 0, 0, 8'h4F);
        chk("full_at_16", 32'(bus.full), 32'd1);
`ifdef ROUTER_FIFO_LEVEL_EN
        chk("level_16", 32'(bus.level), 32'd16);
`endif
        step(1, 0, 0, 8'hEE);
        chk("ovf_set",   32'(bus.overflow_err), 32'd1);
        chk("ovf_full",  32'(bus.full),         32'd1);

        // Full + read + write: only the read happens
        step(1, 1, 0, 8'hAA);
        chk("frw_full",  32'(bus.full),     32'd0);
        chk("frw_data",  32'(bus.data_out), 32'h40);
`ifdef ROUTER_FIFO_LEVEL_EN
        chk("frw_level", 32'(bus.level),    32'd15);
`endif
        for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00);
        chk("drain_last",  32'(bus.data_out), 32'h4F);
        chk("drain_empty", 32'(bus.empty),    32'd1);

        // Empty + read + write: only the write happens
        step(1, 1, 0, 8'h55);
        chk("erw_valid", 32'(bus.out_valid), 32'd0);
        chk("erw_empty", 32'(bus.empty),     32'd0);
        step(0, 1, 0, 8'h00);
        chk("erw_read",  32'(bus.data_out),  32'h55);
        step(0, 0, 0, 8'h00);
        chk("idle_zero", 32'(bus.data_out),  32'h00);

        // Packet: header 0x0C (length 3), 3 payload bytes, parity
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h0C);
        step(1, 0, 0, 8'hA1);
        step(1, 0, 0, 8'hA2);
        step(1, 0, 0, 8'hA3);
        step(1, 0, 0, 8'h5A);
        step(0, 1, 0, 8'h00);
        chk("hdr_data",    32'(bus.data_out), 32'h0C);
        chk("hdr_busy",    32'(bus.pkt_busy), 32'd1);
        chk("model_count", 32'(m_cnt),        32'd4);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        chk("pay_data",    32'(bus.data_out), 32'hA3);
        chk("pay_done",    32'(bus.pkt_done), 32'd0);
        step(0, 1, 0, 8'h00);
        chk("par_data",    32'(bus.data_out), 32'h5A);
        chk("par_done",    32'(bus.pkt_done), 32'd1);
        chk("par_busy",    32'(bus.pkt_busy), 32'd0);
        step(0, 0, 0, 8'h00);
        chk("post_done",   32'(bus.pkt_done), 32'd0);
        chk("post_data",   32'(bus.data_out), 32'h00);

        // Soft reset with 6 entries queued and a packet in progress
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h10);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h61 + 8'(i));
        step(0, 1, 0, 8'h00);
        chk("sr_pre_busy", 32'(bus.pkt_busy),     32'd1);
        chk("sr_pre_ovf",  32'(bus.overflow_err), 32'd1);
        soft_reset = 1'b1;
        step(1, 1, 0, 8'h77);
        soft_reset = 1'b0;
        chk("sr_empty", 32'(bus.empty),        32'd1);
        chk("sr_busy",  32'(bus.pkt_busy),     32'd0);
        chk("sr_ovf",   32'(bus.overflow_err), 32'd0);
        chk("sr_data",  32'(bus.data_out),     32'h00);
        step(1, 0, 0, 8'h3C);
        step(0, 1, 0, 8'h00);
        chk("sr_readback", 32'(bus.data_out), 32'h3C);
        step(0, 0, 0, 8'h00);

        // Pointer wrap with 14 entries standing
        for (int i = 0; i < 13; i++) step(1, 0, 0, 8'h80 + 8'(i));
`ifdef ROUTER_FIFO_LEVEL_EN
        chk("af_13", 32'(bus.almost_full), 32'd0);
`endif
        step(1, 0, 0, 8'h8D);
`ifdef ROUTER_FIFO_LEVEL_EN
        chk("af_14", 32'(bus.almost_full), 32'd1);
`endif
        for (int i = 0; i < 40; i++) step(1, 1, 0, 8'h90 + 8'(i));
        chk("wrap_data", 32'(bus.data_out), 32'hA9);
        step(0, 1, 0, 8'h00);
`ifdef ROUTER_FIFO_LEVEL_EN
        chk("af_drop", 32'(bus.almost_full), 32'd0);
`endif
        for (int i = 0; i < 13; i++) step(0, 1, 0, 8'h00);
        chk("wrap_last",  32'(bus.data_out), 32'hB7);
        chk("wrap_empty", 32'(bus.empty),    32'd1);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
